// File: rtl/irq_pkg.sv
// ============================================================================
//  irq_pkg : shared constants for the timer interrupt consumer.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package irq_pkg;

    // Arbitration FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int MISS_CW_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_prio_enc.sv
// ============================================================================
//  prio_enc : combinational lowest-index-first priority encoder.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req_vec;
        idx   = '0;
        // Descending scan so the lowest set index is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  irq_ctrl : edge-captures timer interrupts into sticky pending bits and
//             presents them one at a time over a req/ack handshake.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2,
    parameter int CW = MISS_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  irq_in,
    input  logic          mask_we,
    input  logic [N-1:0]  mask_wdata,
    output logic [N-1:0]  mask_q,
    output logic [N-1:0]  pending_q,
    output logic          req,
    output logic [IW-1:0] req_id,
    input  logic          ack,
    output logic [CW-1:0] miss_q,
    input  logic          miss_clr
);

    localparam logic [CW-1:0] MISS_SAT = {CW{1'b1}};

    logic [N-1:0]  prev;
    logic [N-1:0]  rise;
    logic [N-1:0]  clr_vec;
    logic          miss_hit;
    logic [1:0]    state;
    logic          enc_valid;
    logic [IW-1:0] enc_idx;

    assign rise = irq_in & ~prev;
    assign req  = (state == ST_REQ);

    always_comb begin
        clr_vec = '0;
        if (state == ST_REQ && ack) begin
            for (int i = 0; i < N; i++) begin
                if (req_id == IW'(i)) begin
                    clr_vec[i] = 1'b1;
                end
            end
        end
    end

    // A rise coinciding with the clear of its own bit re-arms it, not a loss
    assign miss_hit = |(rise & pending_q & ~clr_vec);

    prio_enc #(
        .N  (N),
        .IW (IW)
    ) u_enc (
        .req_vec (pending_q & mask_q),
        .valid   (enc_valid),
        .idx     (enc_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            miss_q    <= '0;
        end else begin
            prev      <= irq_in;
            pending_q <= rise | (pending_q & ~clr_vec);
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            if (miss_clr) begin
                miss_q <= '0;
            end else if (miss_hit && miss_q != MISS_SAT) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            req_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        req_id <= enc_idx;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  tb_irq_ctrl : scoreboard bench for irq_ctrl (CW=8 and CW=2 instances).
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

    localparam int S_PEND  = 0;
    localparam int S_REQ   = 1;
    localparam int S_RID   = 2;
    localparam int S_MISS  = 3;
    localparam int S_MASK  = 4;
    localparam int S_MISS2 = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic       ack = 1'b0;
    logic       miss_clr = 1'b0;

    logic [3:0] mask_q, pending_q, mask2, pending2;
    logic       req, req2;
    logic [1:0] req_id, req_id2;
    logic [7:0] miss_q;
    logic [1:0] miss2;

    int   edges = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    exp_t keep_q[$];

    irq_ctrl #(.N(4), .IW(2), .CW(8)) dut (
        .clk (clk), .rst_n (rst_n), .irq_in (irq_in),
        .mask_we (mask_we), .mask_wdata (mask_wdata), .mask_q (mask_q),
        .pending_q (pending_q), .req (req), .req_id (req_id), .ack (ack),
        .miss_q (miss_q), .miss_clr (miss_clr)
    );

    irq_ctrl #(.N(4), .IW(2), .CW(2)) dut2 (
        .clk (clk), .rst_n (rst_n), .irq_in (irq_in),
        .mask_we (mask_we), .mask_wdata (mask_wdata), .mask_q (mask2),
        .pending_q (pending2), .req (req2), .req_id (req_id2), .ack (ack),
        .miss_q (miss2), .miss_clr (miss_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edges);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_PEND:  return {28'd0, pending_q};
            S_REQ:   return {31'd0, req};
            S_RID:   return {30'd0, req_id};
            S_MISS:  return {24'd0, miss_q};
            S_MASK:  return {28'd0, mask_q};
            default: return {30'd0, miss2};
        endcase
    endfunction

    // Expect signal 'sig' == val once 'd' more rising edges have passed
    task automatic expect_at(input int d, input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        e.cyc = edges + d;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        keep_q.delete();
        foreach (sbq[i]) begin
            if (sbq[i].cyc == edges) begin
                check_val(sbq[i].tag, observe(sbq[i].sig), sbq[i].val);
            end else if (sbq[i].cyc < edges) begin
                check_val({sbq[i].tag, "_expired"}, 32'd1, 32'd0);
            end else begin
                keep_q.push_back(sbq[i]);
            end
        end
        sbq = keep_q;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_pend"}, {28'd0, pending_q}, 32'h0);
        check_val({tag, "_req"},  {31'd0, req},       32'h0);
        check_val({tag, "_rid"},  {30'd0, req_id},    32'h0);
        check_val({tag, "_miss"}, {24'd0, miss_q},    32'h0);
        check_val({tag, "_mask"}, {28'd0, mask_q},    32'hF);
        check_val({tag, "_miss2"}, {30'd0, miss2},    32'h0);
    endtask

    initial begin
        tick(2);
        check_reset_state("rst");
        rst_n = 1'b1;
        tick(2);

        // Single one-cycle pulse on source 0, then acknowledge
        irq_in = 4'b0001;
        expect_at(1, S_PEND, 32'h1, "t1_pend");
        expect_at(1, S_REQ,  32'h0, "t1_req_lat");
        expect_at(2, S_REQ,  32'h1, "t1_req");
        expect_at(2, S_RID,  32'h0, "t1_rid");
        tick(1);
        irq_in = 4'b0000;
        tick(1);
        ack = 1'b1;
        expect_at(1, S_PEND, 32'h0, "t1_clr");
        expect_at(1, S_REQ,  32'h0, "t1_gap");
        expect_at(2, S_REQ,  32'h0, "t1_idle");
        tick(1);
        ack = 1'b0;
        tick(2);

        // Simultaneous sources 1 and 3
        irq_in = 4'b1010;
        expect_at(2, S_REQ, 32'h1, "t2_req_a");
        expect_at(2, S_RID, 32'h1, "t2_rid_a");
        tick(1);
        irq_in = 4'b0000;
        tick(1);
        ack = 1'b1;
        expect_at(1, S_PEND, 32'h8, "t2_pend");
        expect_at(1, S_REQ,  32'h0, "t2_gap");
        expect_at(2, S_REQ,  32'h0, "t2_idle");
        expect_at(3, S_REQ,  32'h1, "t2_req_b");
        expect_at(3, S_RID,  32'h3, "t2_rid_b");
        tick(1);
        ack = 1'b0;
        tick(2);
        ack = 1'b1;
        expect_at(1, S_PEND, 32'h0, "t2_clr");
        expect_at(1, S_MISS, 32'h0, "t2_miss");
        tick(1);
        ack = 1'b0;
        tick(2);

        // Source 2 re-fires three times while pending and unacknowledged
        irq_in = 4'b0100;
        expect_at(1, S_PEND, 32'h4, "t3_pend0");
        expect_at(2, S_RID,  32'h2, "t3_rid0");
        for (int k = 0; k < 3; k++) begin
            tick(1);
            irq_in = 4'b0000;
            tick(1);
            irq_in = 4'b0100;
            expect_at(1, S_MISS, 32'(k + 1), "t3_miss_step");
        end
        expect_at(1, S_PEND, 32'h4, "t3_pend");
        expect_at(1, S_REQ,  32'h1, "t3_req");
        expect_at(1, S_RID,  32'h2, "t3_rid");
        tick(1);
        irq_in = 4'b0000;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);

        // Masked source still latches pending but is not presented
        mask_we = 1'b1;
        mask_wdata = 4'b1110;
        expect_at(1, S_MASK, 32'hE, "t4_mask");
        tick(1);
        mask_we = 1'b0;
        irq_in = 4'b0001;
        expect_at(1, S_PEND, 32'h1, "t4_pend");
        expect_at(2, S_REQ,  32'h0, "t4_noreq_a");
        expect_at(3, S_REQ,  32'h0, "t4_noreq_b");
        tick(1);
        irq_in = 4'b0000;
        tick(1);
        mask_we = 1'b1;
        mask_wdata = 4'b1111;
        expect_at(1, S_REQ, 32'h0, "t4_unmask_lat");
        expect_at(2, S_REQ, 32'h1, "t4_req");
        expect_at(2, S_RID, 32'h0, "t4_rid");
        tick(1);
        mask_we = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);

        // Acknowledge coincides with a new rise on the same source
        irq_in = 4'b0001;
        tick(1);
        irq_in = 4'b0000;
        tick(1);
        ack = 1'b1;
        irq_in = 4'b0001;
        expect_at(1, S_PEND, 32'h1, "t6_pend");
        expect_at(1, S_MISS, 32'h3, "t6_miss");
        expect_at(1, S_REQ,  32'h0, "t6_gap");
        expect_at(2, S_REQ,  32'h0, "t6_idle");
        expect_at(3, S_REQ,  32'h1, "t6_rereq");
        expect_at(3, S_RID,  32'h0, "t6_rid");
        tick(1);
        ack = 1'b0;
        irq_in = 4'b0000;
        tick(2);

        // Asynchronous reset while the request is up
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("t6_async");
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Six pulses on source 1: one capture then five misses
        for (int k = 0; k < 6; k++) begin
            irq_in = 4'b0010;
            tick(1);
            irq_in = 4'b0000;
            tick(1);
        end
        expect_at(1, S_MISS,  32'h5, "t5_miss");
        expect_at(1, S_MISS2, 32'h3, "t5_sat");
        tick(1);
        irq_in = 4'b0010;
        miss_clr = 1'b1;
        expect_at(1, S_MISS2, 32'h0, "t5_clr2");
        expect_at(1, S_MISS,  32'h0, "t5_clr");
        expect_at(2, S_MISS,  32'h0, "t5_clr_hold");
        tick(1);
        irq_in = 4'b0000;
        miss_clr = 1'b0;
        tick(4);

        check_val("sb_drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Consumer end of the timer interrupt line.
- Collects `irq` outputs from up to N timer instances and turns rising edges into sticky pending bits.
- Applies a per-source mask and presents one interrupt at a time to the CPU/sequencer over a `req`/`ack` handshake.
- Counts interrupts lost because a source fired again while its previous event was still pending.

Parameters:
- N, 4, number of interrupt sources (1..16).
- IW, 2, width of `req_id`; must equal max(1, clog2(N)).
- CW, 8, width of the missed-event counter.

Ports:
- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `irq_in` input N: per-source interrupt level from timers; may be one cycle or held high.
- `mask_we` input 1: write strobe for the mask register.
- `mask_wdata` input N: new mask value (1 = enabled).
- `mask_q` output N: current mask.
- `pending_q` output N: current pending bits.
- `req` output 1: interrupt request to the consumer.
- `req_id` output IW: index of the presented source; valid while `req`=1.
- `ack` input 1: consumer acknowledge of `req_id`.
- `miss_q` output CW: saturating count of lost events.
- `miss_clr` input 1: synchronous clear of `miss_q`.

Behaviour:
- Reset (async, `rst_n`=0):
  - prev-level register, `pending_q`, `miss_q`, `req`, `req_id` all 0.
  - `mask_q` resets to all ones.
  - FSM resets to IDLE.
  - Reset mid-handshake drops `req` immediately and discards all pending bits.
- Edge detect: `rise[i]` = `irq_in[i]` & ~`prev[i]`; `prev` <= `irq_in` every cycle. A held-high `irq_in` yields exactly one event.
- Pending update, per bit, each cycle:
  - set if `rise[i]`;
  - else clear if the handshake completes on i (`ack` & `req` & `req_id`==i);
  - else hold.
  - Rise on the same cycle as the clear of the same bit: set wins, no miss counted.
- Miss counter:
  - increments by 1 when `rise[i]` & `pending_q[i]` & not being cleared this cycle.
  - Multiple simultaneous misses in one cycle add 1 only.
  - Saturates at 2^CW-1.
  - `miss_clr` has priority over increment: counter is 0 the next cycle.
- Mask:
  - `mask_q` <= `mask_wdata` on `mask_we`.
  - The mask gates only arbitration, never pending capture.
  - Masked sources still latch pending and count misses.
- FSM:
  - IDLE: `req`=0. If (`pending_q` & `mask_q`) != 0, select the lowest set index, latch `req_id`, go to REQ.
  - REQ: `req`=1, `req_id` held stable. On `ack`, clear `pending_q`[`req_id`] and go to GAP.
  - REQ: mask changes do not withdraw the request.
  - GAP: one cycle with `req`=0, then IDLE. Guarantees a deasserted cycle between requests.
  - `ack` in IDLE or GAP is ignored.
- Latency:
  - `irq_in` first sampled high at edge k: `pending_q` is 1 after edge k.
  - `req` is 1 after edge k+1 if the FSM was IDLE.
  - Minimum acknowledge-to-next-req spacing: 2 cycles.
- Width rule: `req_id` is zero-extended from the encoder. For N=1, `req_id` is constant 0.

Decomposition:
- Package `irq_pkg`:
  - state enum {IDLE, REQ, GAP};
  - localparam for the saturation value (all ones, CW bits).
- Sub-module `prio_enc`, parameterised by N and IW:
  - combinational lowest-index-first encoder;
  - outputs a `valid` flag and an index.
  - Reusable by other arbiters.

Test Plan:
1. Reset, then `irq_in`=4'b0001 for 1 cycle -> `pending_q`=0001 one edge later; `req`=1, `req_id`=0 the next edge. `ack` one cycle -> `pending_q`=0000, `req`=0 for ≥2 cycles.
2. `irq_in`=4'b1010 same cycle, `ack` immediately each time -> `req_id` sequence 1 then 3, with a `req`=0 gap cycle between them. `miss_q`=0.
3. Source 2 rises, no `ack`, source 2 pulses 3 more times -> `miss_q`=3, `pending_q`[2]=1, `req_id`=2 stable throughout.
4. `mask_wdata`=4'b1110 with `mask_we`, then source 0 rises -> `pending_q`=0001, `req` stays 0. Unmask -> `req`=1, `req_id`=0 two edges later.
5. CW=2, force 5 misses on source 1 -> `miss_q` saturates at 3. `miss_clr` pulsed together with a miss -> `miss_q`=0.
6. `ack` in the same cycle as a new rise on `req_id`'s source -> `pending` stays 1, `miss_q` unchanged, `req` re-asserts after the GAP cycle. `rst_n` low while `req`=1 -> `req`=0 asynchronously, all outputs at reset values.
